syn_fifo_v2: RTL and testbench



---
 rtl/syn_fifo_v2_if.sv | 40 ++++
 rtl/syn_fifo_v2.sv | 120 ++++++++++++
 tb/tb_syn_fifo_v2.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/syn_fifo_v2_if.sv
// syn_fifo_v2_if: producer/consumer bundle for syn_fifo_v2.
//
// Handshake: a write is taken on a rising edge when I_winc=1 and O_wfull=0.
// A read (pop) is taken when I_rinc=1 and O_rempty=0. A request made against
// a full or empty FIFO is dropped and reported by a one-cycle O_overflow or
// O_underflow pulse. I_clr flushes the FIFO and wins over both requests.
//
// Modports:
//   master - producer/consumer side: drives I_*, observes O_*
//   slave  - FIFO side: observes I_*, drives O_*
interface syn_fifo_v2_if #(
  parameter int ASIZE = 4,
  parameter int DSIZE = 8
);
  logic             I_clr;
  logic             I_winc;
  logic [DSIZE-1:0] I_wdata;
  logic             I_rinc;
  logic             O_wfull;
  logic             O_wafull;
  logic             O_overflow;
  logic [DSIZE-1:0] O_rdata;
  logic             O_rvalid;
  logic             O_rempty;
  logic             O_raempty;
  logic             O_underflow;
  logic [ASIZE:0]   O_count;

  modport master (
    output I_clr, I_winc, I_wdata, I_rinc,
    input  O_wfull, O_wafull, O_overflow, O_rdata, O_rvalid,
           O_rempty, O_raempty, O_underflow, O_count
  );

  modport slave (
    input  I_clr, I_winc, I_wdata, I_rinc,
    output O_wfull, O_wafull, O_overflow, O_rdata, O_rvalid,
           O_rempty, O_raempty, O_underflow, O_count
  );
endinterface

// File: rtl/syn_fifo_v2.sv
// syn_fifo_v2: single-clock synchronous FIFO with optional first-word-fall-
// through, exact fill count, almost-full/almost-empty flags, overflow and
// underflow pulses and a synchronous flush.
//
// Ports:
//   I_clk   - sole clock, rising edge
//   I_rst_n - asynchronous active-low reset
//   bus     - syn_fifo_v2_if.slave: I_clr, I_winc/I_wdata, I_rinc in;
//             flags, count, O_rdata/O_rvalid and error pulses out
//
// FWFT=0: a pop loads O_rdata from memory, valid (O_rvalid) the next cycle.
// FWFT=1: O_rdata is an output register holding the head word; O_rempty is
//         the inverse of that register's valid bit and O_count includes it.
module syn_fifo_v2 #(
  parameter     MEM_STYLE = "block",
  parameter int ASIZE     = 4,
  parameter int DSIZE     = 8,
  parameter int FWFT      = 0,
  parameter int AF_LEVEL  = (1 << ASIZE) - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  syn_fifo_v2_if.slave  bus
);
  localparam int             DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_LEVEL);

  (* ram_style = MEM_STYLE *)
  logic [DSIZE-1:0] r_mem [DEPTH];

  logic [ASIZE-1:0] r_wptr, r_rptr;
  logic [ASIZE:0]   r_count;
  logic             r_wfull, r_wafull, r_rempty, r_raempty;
  logic             r_overflow, r_underflow, r_rvalid;
  logic [DSIZE-1:0] r_rdata;

  logic             w_wacc, w_racc, w_rd_mem;
  logic             w_rempty_nxt, w_rvalid_nxt;
  logic [ASIZE:0]   w_count_nxt, w_mem_cnt;

  always_comb begin
    w_wacc      = bus.I_winc & ~r_wfull & ~bus.I_clr;
    w_racc      = bus.I_rinc & ~r_rempty & ~bus.I_clr;
    w_count_nxt = r_count + {{ASIZE{1'b0}}, w_wacc} - {{ASIZE{1'b0}}, w_racc};
    // Words still in memory, i.e. not counting the FWFT output register.
    w_mem_cnt   = r_count - {{ASIZE{1'b0}}, ~r_rempty};
    if (FWFT != 0) begin
      // Prefetch when the output register is empty or being popped, using
      // memory contents from before this edge (hence the two-edge latency).
      w_rd_mem     = (r_rempty | w_racc) & (w_mem_cnt != '0) & ~bus.I_clr;
      w_rempty_nxt = ~(w_rd_mem | (~r_rempty & ~w_racc));
      w_rvalid_nxt = ~w_rempty_nxt;
    end else begin
      w_rd_mem     = w_racc;
      w_rempty_nxt = (w_count_nxt == '0);
      w_rvalid_nxt = w_racc;
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge I_clk) begin
    if (w_wacc) r_mem[r_wptr] <= bus.I_wdata;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_wfull     <= 1'b0;
      r_wafull    <= 1'b0;
      r_rempty    <= 1'b1;
      r_raempty   <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else if (bus.I_clr) begin
      // Flush: O_rdata deliberately keeps its last value.
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_wfull     <= 1'b0;
      r_wafull    <= 1'b0;
      r_rempty    <= 1'b1;
      r_raempty   <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rvalid    <= 1'b0;
    end else begin
      if (w_wacc) r_wptr <= r_wptr + ASIZE'(1);
      if (w_rd_mem) begin
        r_rdata <= r_mem[r_rptr];
        r_rptr  <= r_rptr + ASIZE'(1);
      end
      r_count     <= w_count_nxt;
      // Flags come from the next count so they are exact when registered.
      r_wfull     <= (w_count_nxt == DEPTH_C);
      r_wafull    <= (w_count_nxt >= AF_C);
      r_raempty   <= (w_count_nxt <= AE_C);
      r_rempty    <= w_rempty_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_overflow  <= bus.I_winc & r_wfull;
      r_underflow <= bus.I_rinc & r_rempty;
    end
  end

  assign bus.O_count     = r_count;
  assign bus.O_wfull     = r_wfull;
  assign bus.O_wafull    = r_wafull;
  assign bus.O_rempty    = r_rempty;
  assign bus.O_raempty   = r_raempty;
  assign bus.O_overflow  = r_overflow;
  assign bus.O_underflow = r_underflow;
  assign bus.O_rvalid    = r_rvalid;
  assign bus.O_rdata     = r_rdata;
endmodule

// File: tb/tb_syn_fifo_v2.sv
// tb_syn_fifo_v2: drives a standard-mode and an FWFT-mode syn_fifo_v2 with
// identical stimulus and compares both against a queue-based model every
// cycle, plus a table of literal expectations for fill/drain in standard mode.
module tb_syn_fifo_v2;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  syn_fifo_v2_if #(.ASIZE(4), .DSIZE(8)) bus_s ();
  syn_fifo_v2_if #(.ASIZE(4), .DSIZE(8)) bus_f ();

  syn_fifo_v2 #(.ASIZE(4), .DSIZE(8), .FWFT(0)) u_std (
    .I_clk(clk), .I_rst_n(rst_n), .bus(bus_s)
  );
  syn_fifo_v2 #(.ASIZE(4), .DSIZE(8), .FWFT(1)) u_fwft (
    .I_clk(clk), .I_rst_n(rst_n), .bus(bus_f)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Standard: q_s holds every stored word, rd_s/rv_s the read port.
  // FWFT: q_f holds every stored word; vis_f says the head is presented.
  logic [7:0] q_s[$];
  logic [7:0] q_f[$];
  logic [7:0] rd_s;
  logic       rv_s, ovf_s, unf_s;
  logic       vis_f, ovf_f, unf_f;

  task automatic model_reset();
    q_s.delete(); q_f.delete();
    rd_s = 8'h00; rv_s = 0; ovf_s = 0; unf_s = 0;
    vis_f = 0; ovf_f = 0; unf_f = 0;
  endtask

  task automatic model_step(input logic clr, input logic winc,
                            input logic [7:0] wd, input logic rinc);
    logic wa, ra;
    int mw;
    logic [7:0] tmp;
    if (clr) begin
      q_s.delete(); q_f.delete();
      rv_s = 0; ovf_s = 0; unf_s = 0;
      vis_f = 0; ovf_f = 0; unf_f = 0;
    end else begin
      ovf_s = winc && (q_s.size() == 16);
      unf_s = rinc && (q_s.size() == 0);
      wa = winc && (q_s.size() != 16);
      ra = rinc && (q_s.size() != 0);
      rv_s = ra;
      if (ra) rd_s = q_s.pop_front();
      if (wa) q_s.push_back(wd);

      ovf_f = winc && (q_f.size() == 16);
      unf_f = rinc && !vis_f;
      wa = winc && (q_f.size() != 16);
      ra = rinc && vis_f;
      mw = q_f.size() - (vis_f ? 1 : 0);
      if (ra) tmp = q_f.pop_front();
      // Head stays shown unless popped; otherwise shown if memory had words.
      vis_f = (vis_f && !ra) || (mw > 0);
      if (wa) q_f.push_back(wd);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    int ns, nf;
    ns = q_s.size();
    nf = q_f.size();
    chk("s_count",   32'(bus_s.O_count),     ns);
    chk("s_wfull",   32'(bus_s.O_wfull),     32'(ns == 16));
    chk("s_wafull",  32'(bus_s.O_wafull),    32'(ns >= 14));
    chk("s_rempty",  32'(bus_s.O_rempty),    32'(ns == 0));
    chk("s_raempty", 32'(bus_s.O_raempty),   32'(ns <= 2));
    chk("s_ovf",     32'(bus_s.O_overflow),  32'(ovf_s));
    chk("s_unf",     32'(bus_s.O_underflow), 32'(unf_s));
    chk("s_rvalid",  32'(bus_s.O_rvalid),    32'(rv_s));
    chk("s_rdata",   32'(bus_s.O_rdata),     32'(rd_s));
    chk("f_count",   32'(bus_f.O_count),     nf);
    chk("f_wfull",   32'(bus_f.O_wfull),     32'(nf == 16));
    chk("f_wafull",  32'(bus_f.O_wafull),    32'(nf >= 14));
    chk("f_rempty",  32'(bus_f.O_rempty),    32'(!vis_f));
    chk("f_raempty", 32'(bus_f.O_raempty),   32'(nf <= 2));
    chk("f_ovf",     32'(bus_f.O_overflow),  32'(ovf_f));
    chk("f_unf",     32'(bus_f.O_underflow), 32'(unf_f));
    chk("f_rvalid",  32'(bus_f.O_rvalid),    32'(vis_f));
    if (vis_f && nf > 0) chk("f_rdata", 32'(bus_f.O_rdata), 32'(q_f[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic clr, input logic winc,
                       input logic [7:0] wd, input logic rinc);
    bus_s.I_clr = clr; bus_s.I_winc = winc; bus_s.I_wdata = wd; bus_s.I_rinc = rinc;
    bus_f.I_clr = clr; bus_f.I_winc = winc; bus_f.I_wdata = wd; bus_f.I_rinc = rinc;
  endtask

  // Called #1 after a rising edge; applies inputs across the next edge.
  task automatic step(input logic clr, input logic winc,
                      input logic [7:0] wd, input logic rinc);
    drive(clr, winc, wd, rinc);
    model_step(clr, winc, wd, rinc);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 24 && (q_s.size() != 0 || q_f.size() != 0); i++)
      step(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       winc;
    logic       rinc;
    logic [7:0] wdata;
    logic [4:0] cnt;
    logic       full, afull, empty, aempty, ovf, unf, rvalid;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl[34];

  initial begin
    // Fill with 0x00..0x0F, one rejected 0xAA, 16 pops, one rejected pop.
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1, 0, 8'(i), 5'(i+1), (i+1) == 16, (i+1) >= 14, 0,
                 (i+1) <= 2, 0, 0, 0, 8'h00};
    tbl[16] = '{1, 0, 8'hAA, 5'd16, 1, 1, 0, 0, 1, 0, 0, 8'h00};
    for (int j = 0; j < 16; j++)
      tbl[17+j] = '{0, 1, 8'h00, 5'(15-j), 0, (15-j) >= 14, (15-j) == 0,
                    (15-j) <= 2, 0, 0, 1, 8'(j)};
    tbl[33] = '{0, 1, 8'h00, 5'd0, 0, 0, 1, 1, 0, 1, 0, 8'h0F};

    drive(0, 0, 8'h00, 0);
    #1;
    do_reset();

    for (int k = 0; k < 34; k++) begin
      step(0, tbl[k].winc, tbl[k].wdata, tbl[k].rinc);
      chk("t_count",   32'(bus_s.O_count),     32'(tbl[k].cnt));
      chk("t_wfull",   32'(bus_s.O_wfull),     32'(tbl[k].full));
      chk("t_wafull",  32'(bus_s.O_wafull),    32'(tbl[k].afull));
      chk("t_rempty",  32'(bus_s.O_rempty),    32'(tbl[k].empty));
      chk("t_raempty", 32'(bus_s.O_raempty),   32'(tbl[k].aempty));
      chk("t_ovf",     32'(bus_s.O_overflow),  32'(tbl[k].ovf));
      chk("t_unf",     32'(bus_s.O_underflow), 32'(tbl[k].unf));
      chk("t_rvalid",  32'(bus_s.O_rvalid),    32'(tbl[k].rvalid));
      chk("t_rdata",   32'(bus_s.O_rdata),     32'(tbl[k].rdata));
    end
    drive(0, 0, 8'h00, 0);

    // FWFT fall-through: 0x5A shows two edges after its write.
    step(0, 1, 8'h5A, 0);
    chk("fw_empty_n1", 32'(bus_f.O_rempty), 32'd1);
    chk("fw_count_n1", 32'(bus_f.O_count), 32'd1);
    step(0, 1, 8'h00, 0);
    chk("fw_empty_n2", 32'(bus_f.O_rempty), 32'd0);
    chk("fw_rdata_n2", 32'(bus_f.O_rdata), 32'h5A);
    // Streaming write+pop: the head must stay presented every cycle.
    for (int i = 1; i < 64; i++) begin
      step(0, 1, 8'(i), 1);
      chk("fw_nobubble", 32'(bus_f.O_rempty), 32'd0);
    end
    drain();

    // Simultaneous write+read at full and at empty.
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h80 + i), 0);
    step(0, 1, 8'hEE, 1);
    chk("full_rw_cnt_s", 32'(bus_s.O_count), 32'd15);
    chk("full_rw_ovf_s", 32'(bus_s.O_overflow), 32'd1);
    chk("full_rw_cnt_f", 32'(bus_f.O_count), 32'd15);
    chk("full_rw_ovf_f", 32'(bus_f.O_overflow), 32'd1);
    drain();
    step(0, 1, 8'h11, 1);
    chk("empty_rw_cnt_s", 32'(bus_s.O_count), 32'd1);
    chk("empty_rw_unf_s", 32'(bus_s.O_underflow), 32'd1);
    chk("empty_rw_unf_f", 32'(bus_f.O_underflow), 32'd1);
    drain();

    // Randomised traffic across pointer wrap.
    for (int i = 0; i < 100; i++)
      step(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    drain();

    // Flush at count 9, then a fresh word must come out next.
    for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h40 + i), 0);
    chk("clr_pre_cnt", 32'(bus_s.O_count), 32'd9);
    step(1, 1, 8'h99, 1);
    chk("clr_cnt_s", 32'(bus_s.O_count), 32'd0);
    chk("clr_empty_f", 32'(bus_f.O_rempty), 32'd1);
    step(0, 1, 8'h77, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    chk("clr_next_s", 32'(bus_s.O_rdata), 32'h77);
    drain();

    // Reset in the middle of a write burst.
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hC0 + i), i > 2);
    do_reset();
    chk("rst_rdata_s", 32'(bus_s.O_rdata), 32'h00);
    step(0, 1, 8'h33, 0);
    step(0, 0, 8'h00, 0);
    chk("rst_next_f", 32'(bus_f.O_rdata), 32'h33);
    step(0, 0, 8'h00, 1);
    chk("rst_next_s", 32'(bus_s.O_rdata), 32'h33);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
